// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for a 5-stage RV32I pipeline.
// Define HAZARD_FORWARD_EN for EX-stage forwarding; otherwise every RAW dependence stalls.
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ID_valid_i,
  input  logic [REG_AW-1:0] ID_rs1_addr_i,
  input  logic [REG_AW-1:0] ID_rs2_addr_i,
  input  logic              ID_rs1_used_i,
  input  logic              ID_rs2_used_i,
  input  logic [REG_AW-1:0] ID_rd_addr_i,
  input  logic              ID_rd_wren_i,
  input  logic              ID_mem_rden_i,
  input  logic              EX_br_taken_i,
  input  logic              freeze_i,
  output logic [1:0]        EX_forward_rs1_sel_o,
  output logic [1:0]        EX_forward_rs2_sel_o,
  output logic              pc_stall_o,
  output logic              IFID_stall_o,
  output logic              IFID_flush_o,
  output logic              IDEX_flush_o
);

  localparam logic [1:0] NO_FWD  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // The WB slot is not stored: the register file is write-before-read, so it never matters.
  logic              ex_valid_q, ex_wren_q, ex_load_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              mem_valid_q, mem_wren_q;
  logic [REG_AW-1:0] mem_rd_q;

  logic ex_writer, mem_writer;
  logic hit_ex_rs1, hit_ex_rs2, hit_mem_rs1, hit_mem_rs2;
  logic lu_raw, hazard, br;

  assign br         = EX_br_taken_i;
  assign ex_writer  = ex_valid_q && ex_wren_q && (ex_rd_q != '0);
  assign mem_writer = mem_valid_q && mem_wren_q && (mem_rd_q != '0);
  assign hit_ex_rs1  = ID_rs1_used_i && ex_writer  && (ex_rd_q  == ID_rs1_addr_i);
  assign hit_ex_rs2  = ID_rs2_used_i && ex_writer  && (ex_rd_q  == ID_rs2_addr_i);
  assign hit_mem_rs1 = ID_rs1_used_i && mem_writer && (mem_rd_q == ID_rs1_addr_i);
  assign hit_mem_rs2 = ID_rs2_used_i && mem_writer && (mem_rd_q == ID_rs2_addr_i);
  assign lu_raw = ID_valid_i && ex_load_q && (hit_ex_rs1 || hit_ex_rs2);

`ifdef HAZARD_FORWARD_EN
  typedef enum logic {RUN = 1'b0, LUSTALL = 1'b1} state_e;
  state_e     state_q, state_d;
  logic [1:0] rs1_sel_q, rs1_sel_d, rs2_sel_q, rs2_sel_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!freeze_i) begin
      case (state_q)
        RUN:     if (lu_raw && !br) state_d = LUSTALL;
        LUSTALL: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // In LUSTALL the EX slot is always a bubble, so masking lu there only makes that explicit.
  always_comb begin
    hazard = lu_raw && (state_q == RUN);
  end

  always_comb begin
    rs1_sel_d = NO_FWD;
    rs2_sel_d = NO_FWD;
    if (ID_valid_i && !br && !hazard) begin
      if (hit_ex_rs1)       rs1_sel_d = FWD_MEM;
      else if (hit_mem_rs1) rs1_sel_d = FWD_WB;
      if (hit_ex_rs2)       rs2_sel_d = FWD_MEM;
      else if (hit_mem_rs2) rs2_sel_d = FWD_WB;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rs1_sel_q <= NO_FWD;
      rs2_sel_q <= NO_FWD;
    end else if (!freeze_i) begin
      rs1_sel_q <= rs1_sel_d;
      rs2_sel_q <= rs2_sel_d;
    end
  end

  assign EX_forward_rs1_sel_o = rs1_sel_q;
  assign EX_forward_rs2_sel_o = rs2_sel_q;
`else
  // Without forwarding, hold the consumer in ID until its producer has left MEM.
  always_comb begin
    hazard = lu_raw ||
             (ID_valid_i && (hit_ex_rs1 || hit_ex_rs2 || hit_mem_rs1 || hit_mem_rs2));
  end

  assign EX_forward_rs1_sel_o = NO_FWD;
  assign EX_forward_rs2_sel_o = NO_FWD;
`endif

  assign pc_stall_o   = hazard && !br;
  assign IFID_stall_o = hazard && !br;
  assign IFID_flush_o = br;
  assign IDEX_flush_o = br || hazard;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_valid_q  <= 1'b0;
      ex_wren_q   <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_rd_q    <= '0;
    end else if (!freeze_i) begin
      mem_valid_q <= ex_valid_q;
      mem_wren_q  <= ex_wren_q;
      mem_rd_q    <= ex_rd_q;
      ex_valid_q  <= ID_valid_i && !br && !hazard;
      ex_wren_q   <= ID_rd_wren_i;
      ex_load_q   <= ID_mem_rden_i;
      ex_rd_q     <= ID_rd_addr_i;
    end
  end

endmodule
